// File: rtl/osnt_bram_replay.sv
// osnt_bram_replay
//   Replays a packet image held in a BRAM onto an AXI4-Stream master.
//   Each BRAM word holds one stream beat:
//   [511:0] tdata, [639:512] tuser, [703:640] tkeep, [704] valid, [705] last.
//   Words whose valid bit is clear are read but never emitted.
//
// Ports
//   bram_clk, bram_rst      clock, async active-high reset
//   bram_addr/en/we/wrdata  read-only BRAM port (64-byte word stride)
//   bram_rddata             read data, one cycle after bram_en
//   m_axis_*                stream master output
//   replay_start/stop       one-cycle control pulses
//   replay_count            iterations to play (0 = forever)
//   mem_end_word            word index of the last stored word
//   replay_busy/done        status; done is a one-cycle pulse
//   pkt_count               tlast beats accepted since the last start
//
// state | meaning
// IDLE  | waiting for replay_start
// RUN   | issuing reads into the 2-entry output buffer
// DRAIN | no new reads; waiting for buffer and pipeline to empty
// DONE  | one-cycle completion pulse
module osnt_bram_replay #(
    parameter int ADDR_WIDTH           = 20,
    parameter int DATA_WIDTH           = 800,
    parameter int C_M_AXIS_DATA_WIDTH  = 512,
    parameter int C_M_AXIS_TUSER_WIDTH = 128
) (
    input  logic                              bram_clk,
    input  logic                              bram_rst,
    output logic [ADDR_WIDTH-1:0]             bram_addr,
    output logic                              bram_en,
    output logic [DATA_WIDTH/8-1:0]           bram_we,
    output logic [DATA_WIDTH-1:0]             bram_wrdata,
    input  logic [DATA_WIDTH-1:0]             bram_rddata,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    input  logic                              replay_start,
    input  logic                              replay_stop,
    input  logic [31:0]                       replay_count,
    input  logic [ADDR_WIDTH-7:0]             mem_end_word,
    output logic                              replay_busy,
    output logic                              replay_done,
    output logic [31:0]                       pkt_count
);

    localparam int WORD_W    = ADDR_WIDTH - 6;
    localparam int KEEP_W    = C_M_AXIS_DATA_WIDTH / 8;
    localparam int USER_LO   = C_M_AXIS_DATA_WIDTH;
    localparam int KEEP_LO   = USER_LO + C_M_AXIS_TUSER_WIDTH;
    localparam int VALID_BIT = KEEP_LO + KEEP_W;
    localparam int LAST_BIT  = VALID_BIT + 1;
    // Buffer entry: {last, tkeep, tuser, tdata}
    localparam int ENT_W     = VALID_BIT + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   word_idx_q, word_idx_d;
    logic [WORD_W-1:0]   end_q, end_d;
    logic [31:0]         iter_q, iter_d;
    logic [31:0]         count_q, count_d;
    logic                stop_pend_q, stop_pend_d;
    logic                rd_pend_q, rd_pend_d;
    logic [31:0]         pkt_count_q, pkt_count_d;
    logic [ENT_W-1:0]    fifo_q [2];
    logic [ENT_W-1:0]    fifo_d [2];
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          cnt_q, cnt_d;

    logic                pop, push, stop_any, issue, final_read, stop_hit;
    logic [2:0]          occ;
    logic [ENT_W-1:0]    head;
    logic                unused_rddata;

    assign unused_rddata = ^bram_rddata[DATA_WIDTH-1:LAST_BIT+1];

    always_comb begin
        pop      = (cnt_q != 2'd0) && m_axis_tready;
        push     = rd_pend_q && bram_rddata[VALID_BIT];
        stop_any = stop_pend_q || replay_stop;
        // Occupancy after this cycle's pop, counting the read already in flight.
        // Popping here keeps back-to-back reads going when the sink is ready.
        occ      = {1'b0, cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
        // Once stopping, reads are serialised so nothing is issued after the
        // closing last word has come back.
        issue    = (state_q == S_RUN) && (occ < 3'd2) && !(stop_any && rd_pend_q);
        final_read = (word_idx_q == end_q) && (count_q != 32'd0) &&
                     (iter_q + 32'd1 == count_q);
        stop_hit = stop_any && push && bram_rddata[LAST_BIT];
        head     = fifo_q[rd_ptr_q];
    end

    // State register
    always_ff @(posedge bram_clk or posedge bram_rst) begin
        if (bram_rst) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (replay_start) state_d = S_RUN;
            S_RUN:   if ((issue && final_read) || stop_hit) state_d = S_DRAIN;
            S_DRAIN: if ((cnt_q == 2'd0) && !rd_pend_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bram_en       = issue;
        bram_addr     = {word_idx_q, 6'b000000};
        bram_we       = '0;
        bram_wrdata   = '0;
        replay_busy   = (state_q != S_IDLE);
        replay_done   = (state_q == S_DONE);
        m_axis_tvalid = (cnt_q != 2'd0);
        m_axis_tlast  = m_axis_tvalid && head[ENT_W-1];
        m_axis_tdata  = head[C_M_AXIS_DATA_WIDTH-1:0];
        m_axis_tuser  = head[KEEP_LO-1:USER_LO];
        m_axis_tkeep  = head[VALID_BIT-1:KEEP_LO];
        pkt_count     = pkt_count_q;
    end

    // Datapath next-state
    always_comb begin
        word_idx_d  = word_idx_q;
        end_d       = end_q;
        iter_d      = iter_q;
        count_d     = count_q;
        stop_pend_d = stop_pend_q;
        pkt_count_d = pkt_count_q;
        rd_pend_d   = issue;
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q + {1'b0, push} - {1'b0, pop};

        if ((state_q == S_IDLE) && replay_start) begin
            word_idx_d  = '0;
            iter_d      = '0;
            pkt_count_d = '0;
            stop_pend_d = 1'b0;
            count_d     = replay_count;
            end_d       = mem_end_word;
        end
        if (state_q == S_RUN) stop_pend_d = stop_any;

        if (issue) begin
            if (word_idx_q == end_q) begin
                word_idx_d = '0;
                iter_d     = iter_q + 32'd1;
            end else begin
                word_idx_d = word_idx_q + WORD_W'(1);
            end
        end

        if (push) begin
            fifo_d[wr_ptr_q] = {bram_rddata[LAST_BIT], bram_rddata[VALID_BIT-1:0]};
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            if (head[ENT_W-1]) pkt_count_d = pkt_count_q + 32'd1;
        end
    end

    always_ff @(posedge bram_clk or posedge bram_rst) begin
        if (bram_rst) begin
            word_idx_q  <= '0;
            end_q       <= '0;
            iter_q      <= '0;
            count_q     <= '0;
            stop_pend_q <= 1'b0;
            rd_pend_q   <= 1'b0;
            pkt_count_q <= '0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
        end else begin
            word_idx_q  <= word_idx_d;
            end_q       <= end_d;
            iter_q      <= iter_d;
            count_q     <= count_d;
            stop_pend_q <= stop_pend_d;
            rd_pend_q   <= rd_pend_d;
            pkt_count_q <= pkt_count_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_osnt_bram_replay.sv
module tb_osnt_bram_replay;
    localparam int AW = 20;
    localparam int DW = 800;

    logic           bram_clk = 1'b0;
    logic           bram_rst = 1'b1;
    logic [AW-1:0]  bram_addr;
    logic           bram_en;
    logic [DW/8-1:0] bram_we;
    logic [DW-1:0]  bram_wrdata;
    logic [DW-1:0]  bram_rddata = '0;
    logic [511:0]   m_axis_tdata;
    logic [63:0]    m_axis_tkeep;
    logic [127:0]   m_axis_tuser;
    logic           m_axis_tvalid;
    logic           m_axis_tlast;
    logic           m_axis_tready = 1'b1;
    logic           replay_start = 1'b0;
    logic           replay_stop = 1'b0;
    logic [31:0]    replay_count = '0;
    logic [AW-7:0]  mem_end_word = '0;
    logic           replay_busy;
    logic           replay_done;
    logic [31:0]    pkt_count;

    int n_cmp = 0;
    int n_mis = 0;
    int beats_seen = 0;
    int lasts_seen = 0;
    int done_cnt = 0;
    bit last_tlast = 1'b0;
    bit rdy_toggle = 1'b0;
    logic [704:0] sb [$];
    logic [DW-1:0] img [16];

    osnt_bram_replay dut (
        .bram_clk(bram_clk), .bram_rst(bram_rst),
        .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we),
        .bram_wrdata(bram_wrdata), .bram_rddata(bram_rddata),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .replay_start(replay_start), .replay_stop(replay_stop),
        .replay_count(replay_count), .mem_end_word(mem_end_word),
        .replay_busy(replay_busy), .replay_done(replay_done),
        .pkt_count(pkt_count)
    );

    always #5 bram_clk = ~bram_clk;

    // BRAM model: one-cycle read latency
    always @(posedge bram_clk) if (bram_en) bram_rddata <= img[bram_addr[9:6]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input logic [704:0] obs, input logic [704:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL beat: observed=%h expected=%h", obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_word(input bit v, input bit l);
        logic [DW-1:0] w;
        for (int k = 0; k < DW / 32; k++) w[32*k +: 32] = $urandom;
        w[704] = v;
        w[705] = l;
        return w;
    endfunction

    function automatic logic [704:0] exp_beat(input logic [DW-1:0] w);
        return {w[705], w[703:0]};
    endfunction

    // tready driver
    initial begin
        forever begin
            @(posedge bram_clk);
            #1;
            if (rdy_toggle) m_axis_tready = ~m_axis_tready;
            else            m_axis_tready = 1'b1;
        end
    end

    // Monitor / scoreboard: every valid cycle must show the head expected beat
    initial begin
        forever begin
            @(negedge bram_clk);
            if (!bram_rst) begin
                if (replay_done) done_cnt++;
                if (m_axis_tvalid) begin
                    if (sb.size() == 0) begin
                        chk("beat_expected", 64'(sb.size() != 0), 1);
                    end else begin
                        chk_beat({m_axis_tlast, m_axis_tkeep, m_axis_tuser, m_axis_tdata}, sb[0]);
                        if (m_axis_tready) begin
                            void'(sb.pop_front());
                            beats_seen++;
                            if (m_axis_tlast) lasts_seen++;
                            last_tlast = m_axis_tlast;
                        end
                    end
                end
            end
        end
    end

    // Called just after a rising edge; checks start-to-output latency.
    task automatic start_lat(input string tag);
        replay_start = 1'b1;
        @(posedge bram_clk); #1;
        replay_start = 1'b0;
        chk({tag, "_en_t1"}, bram_en, 1);
        chk({tag, "_addr_t1"}, bram_addr, 0);
        @(posedge bram_clk); #1;
        chk({tag, "_valid_t2"}, m_axis_tvalid, 0);
        @(posedge bram_clk); #1;
        chk({tag, "_valid_t3"}, m_axis_tvalid, 1);
    endtask

    task automatic wait_done(input string tag);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < 2000 && done_cnt == d0; i++) @(posedge bram_clk);
        repeat (3) @(posedge bram_clk);
        #1;
        chk({tag, "_done_pulses"}, 64'(done_cnt - d0), 1);
        chk({tag, "_busy"}, replay_busy, 0);
    endtask

    initial begin
        int b0, l0, n;
        for (int i = 0; i < 16; i++) img[i] = '0;
        repeat (3) @(posedge bram_clk);
        #1;
        chk("rst_en", bram_en, 0);
        chk("rst_addr", bram_addr, 0);
        chk("rst_valid", m_axis_tvalid, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_tdata", 64'(|m_axis_tdata), 0);
        chk("rst_busy", replay_busy, 0);
        chk("rst_done", replay_done, 0);
        chk("rst_pkt", pkt_count, 0);
        chk("rst_we", 64'(|bram_we), 0);
        bram_rst = 1'b0;
        @(posedge bram_clk); #1;
        replay_stop = 1'b1;
        @(posedge bram_clk); #1;
        replay_stop = 1'b0;
        chk("idle_stop_busy", replay_busy, 0);

        // Test 1: 4-beat packet, two iterations, tready=1
        for (int i = 0; i < 4; i++) img[i] = mk_word(1'b1, i == 3);
        replay_count = 2; mem_end_word = 3;
        for (int r = 0; r < 2; r++) for (int i = 0; i < 4; i++) sb.push_back(exp_beat(img[i]));
        b0 = beats_seen; l0 = lasts_seen;
        start_lat("t1");
        wait_done("t1");
        chk("t1_pkt", pkt_count, 2);
        chk("t1_beats", 64'(beats_seen - b0), 8);
        chk("t1_lasts", 64'(lasts_seen - l0), 2);
        chk("t1_sb_left", 64'(sb.size()), 0);

        // Test 2: same image, tready toggling
        rdy_toggle = 1'b1;
        for (int r = 0; r < 2; r++) for (int i = 0; i < 4; i++) sb.push_back(exp_beat(img[i]));
        b0 = beats_seen;
        @(posedge bram_clk); #1;
        start_lat("t2");
        wait_done("t2");
        rdy_toggle = 1'b0;
        chk("t2_pkt", pkt_count, 2);
        chk("t2_beats", 64'(beats_seen - b0), 8);
        chk("t2_sb_left", 64'(sb.size()), 0);

        // Test 3: invalid middle word is skipped
        img[0] = mk_word(1'b1, 1'b0);
        img[1] = mk_word(1'b0, 1'b1);
        img[2] = mk_word(1'b1, 1'b1);
        replay_count = 1; mem_end_word = 2;
        sb.push_back(exp_beat(img[0]));
        sb.push_back(exp_beat(img[2]));
        b0 = beats_seen;
        repeat (2) @(posedge bram_clk); #1;
        start_lat("t3");
        wait_done("t3");
        chk("t3_beats", 64'(beats_seen - b0), 2);
        chk("t3_pkt", pkt_count, 1);
        chk("t3_sb_left", 64'(sb.size()), 0);

        // Test 4: single-word image, three iterations
        img[0] = mk_word(1'b1, 1'b1);
        replay_count = 3; mem_end_word = 0;
        for (int i = 0; i < 3; i++) sb.push_back(exp_beat(img[0]));
        b0 = beats_seen;
        @(posedge bram_clk); #1;
        start_lat("t4");
        wait_done("t4");
        chk("t4_beats", 64'(beats_seen - b0), 3);
        chk("t4_pkt", pkt_count, 3);

        // Test 5: infinite replay of two 1-beat packets, stopped after 5 beats
        img[0] = mk_word(1'b1, 1'b1);
        img[1] = mk_word(1'b1, 1'b1);
        replay_count = 0; mem_end_word = 1;
        sb.delete();
        for (int i = 0; i < 20; i++) sb.push_back(exp_beat(img[i % 2]));
        b0 = beats_seen;
        @(posedge bram_clk); #1;
        start_lat("t5");
        for (int i = 0; i < 500 && (beats_seen - b0) < 5; i++) @(posedge bram_clk);
        #1;
        replay_stop = 1'b1;
        @(posedge bram_clk); #1;
        replay_stop = 1'b0;
        wait_done("t5");
        n = beats_seen - b0;
        chk("t5_min_beats", 64'(n >= 5), 1);
        chk("t5_max_beats", 64'(n <= 10), 1);
        chk("t5_end_tlast", last_tlast, 1);
        chk("t5_pkt", pkt_count, 64'(n));
        sb.delete();

        // Test 6: reset mid-packet, then restart from word 0
        for (int i = 0; i < 4; i++) img[i] = mk_word(1'b1, i == 3);
        replay_count = 0; mem_end_word = 3;
        for (int r = 0; r < 3; r++) for (int i = 0; i < 4; i++) sb.push_back(exp_beat(img[i]));
        b0 = beats_seen;
        @(posedge bram_clk); #1;
        start_lat("t6");
        for (int i = 0; i < 500 && (beats_seen - b0) < 2; i++) @(posedge bram_clk);
        #1;
        chk("t6_pre_valid", m_axis_tvalid, 1);
        bram_rst = 1'b1;
        sb.delete();
        #1;
        chk("t6_rst_valid", m_axis_tvalid, 0);
        chk("t6_rst_tlast", m_axis_tlast, 0);
        chk("t6_rst_en", bram_en, 0);
        chk("t6_rst_busy", replay_busy, 0);
        chk("t6_rst_tdata", 64'(|m_axis_tdata), 0);
        @(posedge bram_clk); #1;
        chk("t6_rst_pkt", pkt_count, 0);
        bram_rst = 1'b0;
        replay_count = 1;
        for (int i = 0; i < 4; i++) sb.push_back(exp_beat(img[i]));
        b0 = beats_seen;
        @(posedge bram_clk); #1;
        start_lat("t6r");
        wait_done("t6r");
        chk("t6r_beats", 64'(beats_seen - b0), 4);
        chk("t6r_pkt", pkt_count, 1);
        chk("t6r_sb_left", 64'(sb.size()), 0);

        repeat (5) @(posedge bram_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/osnt_bram_replay.md
OSNT_BRAM_REPLAY -- requirements
Module: osnt_bram_replay

Interface
REQ-001 Parameter ADDR_WIDTH, default 20, meaning BRAM byte-address width; word index is addr[ADDR_WIDTH-1:6].
REQ-002 Parameter DATA_WIDTH, default 800, meaning BRAM word width.
REQ-003 Parameter C_M_AXIS_DATA_WIDTH, default 512, meaning stream data width.
REQ-004 Parameter C_M_AXIS_TUSER_WIDTH, default 128, meaning stream TUSER width.
REQ-005 The block SHALL use one clock, bram_clk; reset bram_rst is asynchronous, active-high.
REQ-006 Ports:
- bram_clk  in  1  clock
- bram_rst  in  1  async active-high reset
- bram_addr  out  ADDR_WIDTH  byte address, low 6 bits always 0
- bram_en  out  1  read enable
- bram_we  out  DATA_WIDTH/8  tied 0
- bram_wrdata  out  DATA_WIDTH  tied 0
- bram_rddata  in  DATA_WIDTH  read data, valid 1 cycle after bram_en
- m_axis_tdata  out  512  stream data
- m_axis_tkeep  out  64  byte enables
- m_axis_tuser  out  128  sideband
- m_axis_tvalid  out  1  valid
- m_axis_tlast  out  1  end of packet
- m_axis_tready  in  1  sink ready
- replay_start  in  1  one-cycle start pulse
- replay_stop  in  1  one-cycle stop pulse
- replay_count  in  32  iterations to play; 0 = infinite
- mem_end_word  in  ADDR_WIDTH-6  word index of last stored word
- replay_busy  out  1  high while not IDLE
- replay_done  out  1  one-cycle completion pulse
- pkt_count  out  32  packets emitted (tlast beats) since start

Function
REQ-007 Word layout SHALL be: [511:0] tdata, [639:512] tuser, [703:640] tkeep, [704] valid, [705] last, [799:706] ignored.
REQ-008 States SHALL be IDLE, RUN, DRAIN, DONE.
REQ-009 IDLE: replay_start=1 -> RUN; word index, iteration counter and pkt_count cleared to 0; replay_count and mem_end_word latched.
REQ-010 RUN: bram_en SHALL be asserted only when the output buffer (2 entries) has space for all reads in flight plus the new one; no word is ever dropped or duplicated under any tready pattern.
REQ-011 Latency: replay_start at edge T -> bram_en=1, bram_addr=0 in cycle T+1 -> m_axis_tvalid=1 in cycle T+3 if the output buffer is empty.
REQ-012 Each read advances the word index by 1 (bram_addr by 64); after reading mem_end_word the index wraps to 0 and the iteration counter increments.
REQ-013 Words with valid bit 0 SHALL be discarded, not emitted, and do not count.
REQ-014 Once m_axis_tvalid=1, tdata/tkeep/tuser/tlast SHALL hold stable until tvalid&tready.
REQ-015 Read issue SHALL stop after the read of mem_end_word in iteration replay_count (nonzero); then -> DRAIN.
REQ-016 replay_stop in RUN: continue issuing reads until a word with last=1 has been read, then -> DRAIN; replay_stop in IDLE/DRAIN/DONE is ignored.
REQ-017 replay_start while not IDLE SHALL be ignored.
REQ-018 DRAIN: no reads; after output buffer empty and no reads pending -> DONE.
REQ-019 DONE: replay_done=1 for exactly one cycle, -> IDLE.
REQ-020 tlast is taken from memory unmodified; pkt_count increments on each tvalid&tready&tlast, wrapping at 2^32.
REQ-021 mem_end_word=0 SHALL replay word 0 once per iteration.

Reset
REQ-022 bram_rst asserted SHALL immediately force: state IDLE, bram_en=0, bram_addr=0, m_axis_tvalid=0, m_axis_tlast=0, tdata/tkeep/tuser=0, replay_busy=0, replay_done=0, pkt_count=0, buffer emptied.
REQ-023 Reset mid-packet SHALL discard in-flight reads; next start begins at word 0.

Verification
REQ-024 Words 0..3 = one 4-beat packet (last on word 3), end=3, count=2, tready=1 -> 8 beats, tlast on beats 4 and 8, pkt_count=2, one replay_done.
REQ-025 Same image, tready toggling 1/0 every cycle -> identical beat sequence and data, no loss/duplication, tvalid data stable while tready=0.
REQ-026 Word 1 valid=0, end=2, count=1 -> only words 0 and 2 emitted.
REQ-027 count=0, two 1-beat packets, replay_stop after 5 beats -> stream ends on a tlast beat, replay_done pulses, state IDLE.
REQ-028 bram_rst asserted with tvalid=1 mid-packet -> tvalid=0 same cycle; restart emits word 0 first with tvalid in cycle T+3.
